mips_mc_control: RTL and testbench

Main control state machine for the multicycle MIPS datapath. Decodes the opcode latched in the instruction register and sequences fetch, decode, execute, memory and writeback steps. Produces the per-cycle write enables that drive the datapath's enabled 32-bit registers (PC, IR) and the register file, plus all datapath mux selects. Memory accesses use a ready handshake, so multi-cycle memories stall the sequence.

---
 rtl/mips_mc_control.sv | 209 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch / decode / execute / memory / writeback steps from the
//            opcode held in the instruction register, and drives all write
//            enables and datapath mux selects. Memory steps wait on a ready
//            handshake so slow memories stall the sequence.
// Ports    : i_clk, i_reset           - clock, synchronous active-high reset
//            i_opcode                 - instr[31:26] from IR
//            i_zero                   - ALU zero flag (branch decision)
//            i_mem_ready              - memory finished current access
//            o_mem_req/o_iord/o_mem_write - memory request, address select,
//                                       write strobe
//            o_ir_write/o_pc_en/o_reg_write - register write enables
//            o_reg_dst/o_mem_to_reg/o_alu_src_a/o_alu_src_b/o_alu_op/
//            o_pc_src                 - datapath mux selects
//            o_illegal                - pulse on unsupported opcode in DECODE
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_pc_en,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_illegal
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_pc_write;
    logic w_branch;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The opcode only matters in DECODE and MEMADR.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // The opcode is re-sampled here; anything other than lw/sw
                // abandons the instruction rather than touching memory.
                if (i_opcode == c_OP_LW)      w_next = S_MEMREAD;
                else if (i_opcode == c_OP_SW) w_next = S_MEMWRITE;
                else                          w_next = S_FETCH;
            end
            S_MEMREAD:  if (i_mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (i_mem_ready) w_next = S_FETCH;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEXEC: w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Reset forces every enable low and shows the FETCH
    // selects, regardless of whatever state the register still holds.
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_req    = 1'b0;
        o_iord       = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_pc_src     = 2'b00;
        o_illegal    = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;

        if (i_reset) begin
            o_alu_src_b = 2'b01;
        end else begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req   = 1'b1;
                    o_alu_src_b = 2'b01;
                    // IR and PC only update on the cycle the fetch completes.
                    o_ir_write  = i_mem_ready;
                    w_pc_write  = i_mem_ready;
                end
                S_DECODE: begin
                    o_alu_src_b = 2'b11;
                    case (i_opcode)
                        c_OP_RTYPE, c_OP_LW, c_OP_SW,
                        c_OP_BEQ, c_OP_ADDI, c_OP_J: o_illegal = 1'b0;
                        default:                     o_illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    o_mem_req = 1'b1;
                    o_iord    = 1'b1;
                end
                S_MEMWB: begin
                    o_mem_to_reg = 1'b1;
                    o_reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    o_mem_req   = 1'b1;
                    o_iord      = 1'b1;
                    o_mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    o_reg_dst   = 1'b1;
                    o_reg_write = 1'b1;
                end
                S_BRANCH: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b01;
                    o_pc_src    = 2'b01;
                    w_branch    = 1'b1;
                end
                S_ADDIEXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                S_ADDIWB: begin
                    o_reg_write = 1'b1;
                end
                S_JUMP: begin
                    o_pc_src   = 2'b10;
                    w_pc_write = 1'b1;
                end
                default: begin
                    o_alu_src_b = 2'b01;
                end
            endcase
        end
    end

    assign o_pc_en = w_pc_write | (w_branch & i_zero);

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_control
// Purpose  : Scoreboard bench for mips_mc_control. The stimulus process
//            drives one cycle of inputs at a time and pushes the output
//            vector expected in that cycle; a monitor pops and compares on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_BAD  = 6'b111111;

    localparam int c_F = 0, c_DEC = 1, c_MA = 2, c_MR = 3, c_MWB = 4,
                   c_MW = 5, c_EX = 6, c_AWB = 7, c_BR = 8, c_AE = 9,
                   c_AIWB = 10, c_JMP = 11;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, pc_en, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;

    mips_mc_control dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_opcode     (opcode),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_mem_req    (mem_req),
        .o_iord       (iord),
        .o_mem_write  (mem_write),
        .o_ir_write   (ir_write),
        .o_pc_en      (pc_en),
        .o_reg_write  (reg_write),
        .o_reg_dst    (reg_dst),
        .o_mem_to_reg (mem_to_reg),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_alu_op     (alu_op),
        .o_pc_src     (pc_src),
        .o_illegal    (illegal)
    );

    // Negedge at 5, posedge at 10: the first driven cycle is checked before
    // the first rising edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    logic [15:0] w_act;
    assign w_act = {mem_req, iord, mem_write, ir_write, pc_en, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_src, illegal};

    logic [15:0] q_exp[$];
    int          q_st[$];
    int          q_cyc[$];
    int          tests;
    int          fails;
    int          cyc;

    // Expected outputs, taken straight from the state table.
    function automatic logic [15:0] expv(input int st, input logic rdy,
                                         input logic z, input logic ill,
                                         input logic r);
        logic mreq, ia, mw, irw, pce, rw, rd, m2r, sa, il;
        logic [1:0] sb, ao, ps;
        mreq = 0; ia = 0; mw = 0; irw = 0; pce = 0; rw = 0; rd = 0;
        m2r = 0; sa = 0; il = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
        if (r) begin
            sb = 2'b01;
        end else begin
            case (st)
                c_F:    begin mreq = 1; sb = 2'b01; irw = rdy; pce = rdy; end
                c_DEC:  begin sb = 2'b11; il = ill; end
                c_MA:   begin sa = 1; sb = 2'b10; end
                c_MR:   begin mreq = 1; ia = 1; end
                c_MWB:  begin m2r = 1; rw = 1; end
                c_MW:   begin mreq = 1; ia = 1; mw = 1; end
                c_EX:   begin sa = 1; ao = 2'b10; end
                c_AWB:  begin rd = 1; rw = 1; end
                c_BR:   begin sa = 1; ao = 2'b01; ps = 2'b01; pce = z; end
                c_AE:   begin sa = 1; sb = 2'b10; end
                c_AIWB: begin rw = 1; end
                c_JMP:  begin ps = 2'b10; pce = 1; end
                default: ;
            endcase
        end
        return {mreq, ia, mw, irw, pce, rw, rd, m2r, sa, sb, ao, ps, il};
    endfunction

    // One clock cycle of stimulus plus its expected output.
    task automatic step(input int st, input logic [5:0] op, input logic rdy,
                        input logic z, input logic r, input logic ill);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        q_exp.push_back(expv(st, rdy, z, ill, r));
        q_st.push_back(st);
        q_cyc.push_back(cyc);
        cyc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            logic [15:0] e;
            int          s;
            int          c;
            e = q_exp.pop_front();
            s = q_st.pop_front();
            c = q_cyc.pop_front();
            tests = tests + 1;
            if (w_act !== e) begin
                fails = fails + 1;
                $display("FAIL outputs cycle=%0d state=%0d actual=%b required=%b",
                         c, s, w_act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst = 1; opcode = c_BAD; zero = 0; mem_ready = 0;

        // Reset, with the memory reporting ready and zero high: still no
        // enables.
        step(c_F, c_BAD, 1, 1, 1, 0);
        step(c_F, c_BAD, 0, 0, 1, 0);

        // Reset in the middle of a MEMREAD wait.
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_LW,  1, 0, 0, 0);
        step(c_MA,  c_LW,  1, 0, 0, 0);
        step(c_MR,  c_BAD, 0, 0, 0, 0);
        step(c_MR,  c_BAD, 1, 0, 1, 0);   // reset while waiting
        // R-type, zero wait (also proves we came back in FETCH).
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_RT,  1, 0, 0, 0);
        step(c_EX,  c_BAD, 1, 1, 0, 0);
        step(c_AWB, c_BAD, 1, 1, 0, 0);

        // lw with 2 FETCH stalls and 3 MEMREAD stalls: 10 cycles.
        step(c_F,   c_BAD, 0, 1, 0, 0);
        step(c_F,   c_BAD, 0, 0, 0, 0);
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_LW,  1, 0, 0, 0);
        step(c_MA,  c_LW,  1, 0, 0, 0);
        step(c_MR,  c_BAD, 0, 0, 0, 0);
        step(c_MR,  c_SW,  0, 1, 0, 0);
        step(c_MR,  c_BAD, 0, 0, 0, 0);
        step(c_MR,  c_BAD, 1, 0, 0, 0);
        step(c_MWB, c_BAD, 1, 0, 0, 0);

        // beq taken, then not taken.
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_BEQ, 1, 0, 0, 0);
        step(c_BR,  c_BAD, 1, 1, 0, 0);
        step(c_F,   c_BAD, 1, 1, 0, 0);
        step(c_DEC, c_BEQ, 1, 1, 0, 0);
        step(c_BR,  c_BAD, 1, 0, 0, 0);

        // sw with two write-wait cycles.
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_SW,  1, 0, 0, 0);
        step(c_MA,  c_SW,  1, 0, 0, 0);
        step(c_MW,  c_BAD, 0, 0, 0, 0);
        step(c_MW,  c_LW,  0, 0, 0, 0);
        step(c_MW,  c_BAD, 1, 0, 0, 0);

        // j
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_J,   1, 0, 0, 0);
        step(c_JMP, c_BAD, 1, 0, 0, 0);

        // addi
        step(c_F,    c_BAD,  1, 0, 0, 0);
        step(c_DEC,  c_ADDI, 1, 0, 0, 0);
        step(c_AE,   c_BAD,  1, 0, 0, 0);
        step(c_AIWB, c_BAD,  1, 0, 0, 0);

        // Illegal opcode: pulse in DECODE, straight back to FETCH.
        step(c_F,   c_RT,  1, 0, 0, 0);
        step(c_DEC, c_BAD, 1, 0, 0, 1);
        step(c_F,   c_BAD, 0, 0, 0, 0);
        step(c_F,   c_BAD, 1, 0, 0, 0);
        step(c_DEC, c_RT,  1, 0, 0, 0);

        // Let the monitor drain the queue.
        for (int i = 0; i < 4 && q_exp.size() > 0; i++) @(negedge clk);
        tests = tests + 1;
        if (q_exp.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: actual=%0d pending required=0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
